capture_sequencer: RTL and testbench

Sys-clock-domain controller for the ADC LVDS front-end snapshot path. It runs a programmed number of back-to-back snapshot captures. For each capture it waits for lane alignment, issues a one-cycle trigger, gates the AXIS ready, and counts exactly snap_len accepted beats. It sits between the CSR block and the front-end output stream, replacing free-running trigger logic, and reports completion, abort and error status back to the CSRs.

---
 rtl/adc_fe_pkg.sv | 20 ++
 rtl/capture_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_capture_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg
// Shared types and default widths for the ADC LVDS front-end control blocks.
//   seq_state_t : capture_sequencer FSM state encoding
//   DEF_*       : default parameter widths used by the front-end modules
package adc_fe_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_NCAP_W = 8;
  localparam int DEF_TO_W   = 24;
  localparam int HOLD_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ALIGN,
    CAPTURE,
    HOLDOFF,
    DONE
  } seq_state_t;

endpackage

// File: rtl/capture_sequencer.sv
// capture_sequencer
// Runs a programmed number of back-to-back snapshot captures on the front-end
// AXIS output. Each capture waits for lane alignment, fires a one-cycle
// trigger, opens capture_en and closes it on exactly the snap_len-th beat.
//
// Ports
//   sys_clk, rst_n        clock, async active-low reset
//   start, abort          CSR strobes (abort wins when both are high)
//   snap_len              beats per capture        (latched at accepted start)
//   num_captures          captures per run         (latched at accepted start)
//   holdoff               idle cycles between captures (latched)
//   align_timeout         max WAIT_ALIGN cycles, 0 = forever (latched)
//   aligned               front-end alignment status (sys_clk domain)
//   axis_valid/axis_ready raw stream handshake, ready before gating
//   capture_en            gate for stream_enable and out_ready
//   trigger               one-cycle pulse at the start of each capture
//   busy, done            run status
//   cap_idx, beat_cnt     progress of the current capture
//   err_*                 sticky error flags, cleared by the next accepted start
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no run; waiting for start
// WAIT_ALIGN | waiting for aligned, optional timeout via down-counter
// CAPTURE    | capture_en open, counting accepted beats
// HOLDOFF    | gap between captures, down-counter runs holdoff+1 cycles
// DONE       | one-cycle done pulse, then IDLE
module capture_sequencer
  import adc_fe_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TO_W   = DEF_TO_W,
  parameter int NCAP_W = DEF_NCAP_W
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  snap_len,
  input  logic [NCAP_W-1:0] num_captures,
  input  logic [15:0]       holdoff,
  input  logic [TO_W-1:0]   align_timeout,
  input  logic              aligned,
  input  logic              axis_valid,
  input  logic              axis_ready,
  output logic              capture_en,
  output logic              trigger,
  output logic              busy,
  output logic              done,
  output logic [NCAP_W-1:0] cap_idx,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              err_cfg,
  output logic              err_align_to,
  output logic              err_align_lost
);

  // One down-counter serves both the alignment timeout and the holdoff gap;
  // the two phases never overlap.
  localparam int DCNT_W = (TO_W > HOLD_W) ? TO_W : HOLD_W;

  seq_state_t state, state_nxt;

  logic [CNT_W-1:0]  snap_len_q;
  logic [NCAP_W-1:0] ncap_q;
  logic [HOLD_W-1:0] holdoff_q;
  logic [TO_W-1:0]   to_q;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;

  logic beat, last_beat, cfg_ok, accept, to_expire, hold_expire, more_caps;

  logic              capture_en_nxt, trigger_nxt, busy_nxt, done_nxt;
  logic [NCAP_W-1:0] cap_idx_nxt;
  logic [CNT_W-1:0]  beat_cnt_nxt;
  logic              err_cfg_nxt, err_align_to_nxt, err_align_lost_nxt;

  assign beat        = axis_valid & axis_ready & capture_en;
  assign last_beat   = beat && (beat_cnt == snap_len_q - CNT_W'(1));
  assign cfg_ok      = (snap_len != '0) && (num_captures != '0);
  assign accept      = (state == IDLE) && start && !abort && cfg_ok;
  // Counter is loaded with align_timeout on entry, so it reads 1 during the
  // last permitted waiting cycle.
  assign to_expire   = (to_q != '0) && (dcnt <= DCNT_W'(1));
  assign hold_expire = (dcnt == '0);
  // ncap_q is never 0 inside a run, so the subtraction cannot underflow.
  assign more_caps   = (cap_idx < ncap_q - NCAP_W'(1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      snap_len_q     <= '0;
      ncap_q         <= '0;
      holdoff_q      <= '0;
      to_q           <= '0;
      dcnt           <= '0;
      capture_en     <= 1'b0;
      trigger        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cap_idx        <= '0;
      beat_cnt       <= '0;
      err_cfg        <= 1'b0;
      err_align_to   <= 1'b0;
      err_align_lost <= 1'b0;
    end else begin
      state          <= state_nxt;
      dcnt           <= dcnt_nxt;
      capture_en     <= capture_en_nxt;
      trigger        <= trigger_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      cap_idx        <= cap_idx_nxt;
      beat_cnt       <= beat_cnt_nxt;
      err_cfg        <= err_cfg_nxt;
      err_align_to   <= err_align_to_nxt;
      err_align_lost <= err_align_lost_nxt;
      if (accept) begin
        snap_len_q <= snap_len;
        ncap_q     <= num_captures;
        holdoff_q  <= holdoff;
        to_q       <= align_timeout;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       if (accept) state_nxt = WAIT_ALIGN;
        WAIT_ALIGN: begin
          if (aligned)        state_nxt = CAPTURE;
          else if (to_expire) state_nxt = IDLE;
        end
        CAPTURE: begin
          if (!aligned)       state_nxt = IDLE;
          else if (last_beat) state_nxt = more_caps ? HOLDOFF : DONE;
        end
        HOLDOFF:    if (hold_expire) state_nxt = WAIT_ALIGN;
        DONE:       state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    capture_en_nxt     = (state_nxt == CAPTURE);
    trigger_nxt        = (state_nxt == CAPTURE) && (state != CAPTURE);
    busy_nxt           = (state_nxt != IDLE);
    done_nxt           = (state_nxt == DONE);
    cap_idx_nxt        = cap_idx;
    beat_cnt_nxt       = beat_cnt;
    err_cfg_nxt        = err_cfg;
    err_align_to_nxt   = err_align_to;
    err_align_lost_nxt = err_align_lost;
    dcnt_nxt           = dcnt;

    // A handshake in the cycle an abort or alignment loss arrives is a real
    // transfer downstream, so it is still counted.
    if (beat && beat_cnt != '1) beat_cnt_nxt = beat_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (accept) begin
          err_cfg_nxt        = 1'b0;
          err_align_to_nxt   = 1'b0;
          err_align_lost_nxt = 1'b0;
          cap_idx_nxt        = '0;
          beat_cnt_nxt       = '0;
          dcnt_nxt           = DCNT_W'(align_timeout);
        end else if (start && !abort && !cfg_ok) begin
          err_cfg_nxt = 1'b1;
        end
      end
      WAIT_ALIGN: begin
        if (state_nxt == CAPTURE) beat_cnt_nxt = '0;
        if (!abort && !aligned && to_expire) err_align_to_nxt = 1'b1;
        if (state_nxt == WAIT_ALIGN && to_q != '0 && dcnt != '0)
          dcnt_nxt = dcnt - DCNT_W'(1);
      end
      CAPTURE: begin
        if (!abort && !aligned) err_align_lost_nxt = 1'b1;
        if (state_nxt == HOLDOFF) begin
          cap_idx_nxt = cap_idx + NCAP_W'(1);
          dcnt_nxt    = DCNT_W'(holdoff_q);
        end
      end
      HOLDOFF: begin
        if (state_nxt == WAIT_ALIGN) dcnt_nxt = DCNT_W'(to_q);
        else if (dcnt != '0)         dcnt_nxt = dcnt - DCNT_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;
  localparam int CNT_W  = 32;
  localparam int TO_W   = 24;
  localparam int NCAP_W = 8;

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  snap_len = '0;
  logic [NCAP_W-1:0] num_captures = '0;
  logic [15:0]       holdoff = '0;
  logic [TO_W-1:0]   align_timeout = '0;
  logic              aligned = 1'b0;
  logic              axis_valid = 1'b0;
  logic              axis_ready = 1'b0;
  logic              capture_en, trigger, busy, done;
  logic [NCAP_W-1:0] cap_idx;
  logic [CNT_W-1:0]  beat_cnt;
  logic              err_cfg, err_align_to, err_align_lost;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  capture_sequencer #(.CNT_W(CNT_W), .TO_W(TO_W), .NCAP_W(NCAP_W)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .snap_len(snap_len), .num_captures(num_captures), .holdoff(holdoff),
    .align_timeout(align_timeout), .aligned(aligned), .axis_valid(axis_valid),
    .axis_ready(axis_ready), .capture_en(capture_en), .trigger(trigger),
    .busy(busy), .done(done), .cap_idx(cap_idx), .beat_cnt(beat_cnt),
    .err_cfg(err_cfg), .err_align_to(err_align_to), .err_align_lost(err_align_lost)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event recorder: times are relative to the cycle in which start was driven.
  bit mon_en = 1'b0;
  int t0 = 0;
  int trig_cyc[$];
  int trig_idx[$];
  int trig_capen[$];
  int lb_cyc[$];
  int cap_beats[$];
  int beat_total, done_cnt, done_cyc, last_beat, err_to_cyc;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (trigger) begin
        if (trig_cyc.size() > 0) lb_cyc.push_back(last_beat);
        trig_cyc.push_back(cyc - t0);
        trig_idx.push_back(int'(cap_idx));
        trig_capen.push_back(int'(capture_en));
        cap_beats.push_back(0);
      end
      if (axis_valid && axis_ready && capture_en) begin
        beat_total++;
        last_beat = cyc - t0;
        if (cap_beats.size() > 0) cap_beats[cap_beats.size()-1] = cap_beats[cap_beats.size()-1] + 1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      if (err_align_to && err_to_cyc < 0 && (cyc - t0) > 0) err_to_cyc = cyc - t0;
    end
  end

  task automatic clear_mon();
    trig_cyc.delete(); trig_idx.delete(); trig_capen.delete();
    lb_cyc.delete(); cap_beats.delete();
    beat_total = 0; done_cnt = 0; done_cyc = -1; last_beat = -1; err_to_cyc = -1;
    t0 = cyc;
    mon_en = 1'b1;
  endtask

  // Drives one run; mid-run it scrambles the CSR inputs and pulses start,
  // neither of which may affect the run in progress.
  task automatic run_capture(input int snap, input int ncap, input int hold,
                             input bit rnd, output bit finished);
    bit poked;
    @(posedge sys_clk); #1;
    snap_len = CNT_W'(snap); num_captures = NCAP_W'(ncap);
    holdoff = 16'(hold); align_timeout = '0;
    aligned = 1'b1; axis_valid = 1'b1; axis_ready = 1'b1; abort = 1'b0; start = 1'b1;
    clear_mon();
    finished = 1'b0; poked = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge sys_clk); #1;
      start = 1'b0;
      if (done_cnt > 0 && !busy) begin finished = 1'b1; break; end
      if (rnd) begin
        axis_valid = ($urandom_range(0, 3) != 0);
        axis_ready = 1'($urandom_range(0, 1));
      end
      if (!poked && trig_cyc.size() > 0) begin
        snap_len = CNT_W'($urandom_range(1, 50));
        num_captures = NCAP_W'($urandom_range(1, 9));
        holdoff = 16'($urandom_range(0, 40));
        start = 1'b1; poked = 1'b1;
      end
    end
    mon_en = 1'b0;
    axis_valid = 1'b1; axis_ready = 1'b1;
  endtask

  task automatic test_reset();
    total++; if ({capture_en, trigger, busy, done, err_cfg, err_align_to, err_align_lost} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000", {capture_en, trigger, busy, done, err_cfg, err_align_to, err_align_lost}); end
    total++; if (cap_idx !== '0 || beat_cnt !== '0) begin
      bad++; $display("FAIL reset_counts: got cap_idx=%0d beat_cnt=%0d want 0 0", cap_idx, beat_cnt); end
    @(posedge sys_clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge sys_clk); #1;
    total++; if ({capture_en, trigger, busy, done} !== 4'b0) begin
      bad++; $display("FAIL idle_after_reset: got %b want 0000", {capture_en, trigger, busy, done}); end
  endtask

  task automatic test_single();
    bit fin;
    run_capture(16, 1, 0, 1'b0, fin);
    total++; if (!fin) begin bad++; $display("FAIL single_finish: run did not complete in budget"); end
    total++; if (trig_cyc.size() !== 1) begin bad++; $display("FAIL single_trig_count: got %0d want 1", trig_cyc.size()); end
    total++; if ((trig_cyc.size() > 0 ? trig_cyc[0] : -1) !== 2) begin
      bad++; $display("FAIL single_trig_cycle: got %0d want 2", trig_cyc.size() > 0 ? trig_cyc[0] : -1); end
    total++; if ((trig_capen.size() > 0 ? trig_capen[0] : 0) !== 1) begin
      bad++; $display("FAIL single_capen_with_trig: got 0 want 1"); end
    total++; if (beat_total !== 16) begin bad++; $display("FAIL single_beats: got %0d want 16", beat_total); end
    total++; if (done_cnt !== 1 || done_cyc !== 18) begin
      bad++; $display("FAIL single_done: got count=%0d cycle=%0d want 1 18", done_cnt, done_cyc); end
    total++; if (busy !== 1'b0 || capture_en !== 1'b0) begin
      bad++; $display("FAIL single_idle: got busy=%0d capture_en=%0d want 0 0", busy, capture_en); end
    total++; if (beat_cnt !== 16) begin bad++; $display("FAIL single_beat_cnt: got %0d want 16", beat_cnt); end
  endtask

  task automatic test_multi();
    bit fin;
    run_capture(8, 3, 5, 1'b0, fin);
    total++; if (!fin) begin bad++; $display("FAIL multi_finish: run did not complete in budget"); end
    total++; if (trig_cyc.size() !== 3) begin bad++; $display("FAIL multi_trig_count: got %0d want 3", trig_cyc.size()); end
    total++; if (beat_total !== 24) begin bad++; $display("FAIL multi_beats: got %0d want 24", beat_total); end
    for (int k = 0; k < trig_idx.size(); k++) begin
      total++; if (trig_idx[k] !== k) begin bad++; $display("FAIL multi_cap_idx%0d: got %0d want %0d", k, trig_idx[k], k); end
    end
    // Last beat to next trigger: 1 + holdoff + 1 + 1 edges, i.e. 7 idle cycles.
    for (int k = 0; k < lb_cyc.size(); k++) begin
      total++; if (trig_cyc[k+1] - lb_cyc[k] !== 8) begin
        bad++; $display("FAIL multi_gap%0d: got %0d want 8", k, trig_cyc[k+1] - lb_cyc[k]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL multi_done_count: got %0d want 1", done_cnt); end
    total++; if (cap_idx !== 2) begin bad++; $display("FAIL multi_final_idx: got %0d want 2", cap_idx); end
  endtask

  task automatic test_backpressure();
    bit fin;
    run_capture(10, 1, 0, 1'b1, fin);
    total++; if (!fin) begin bad++; $display("FAIL bp_finish: run did not complete in budget"); end
    total++; if (beat_total !== 10) begin bad++; $display("FAIL bp_beats: got %0d want 10", beat_total); end
    total++; if (done_cnt !== 1 || done_cyc !== last_beat + 1) begin
      bad++; $display("FAIL bp_done: got count=%0d cycle=%0d want 1 %0d", done_cnt, done_cyc, last_beat + 1); end
  endtask

  task automatic test_random_runs();
    bit fin;
    int snap, ncap, hold;
    for (int it = 0; it < 5; it++) begin
      snap = $urandom_range(1, 12); ncap = $urandom_range(1, 3); hold = $urandom_range(0, 6);
      run_capture(snap, ncap, hold, 1'b1, fin);
      total++; if (!fin) begin bad++; $display("FAIL rnd%0d_finish: run did not complete", it); end
      total++; if (trig_cyc.size() !== ncap) begin
        bad++; $display("FAIL rnd%0d_trigs: got %0d want %0d", it, trig_cyc.size(), ncap); end
      total++; if (beat_total !== snap * ncap) begin
        bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", it, beat_total, snap * ncap); end
      total++; if ((trig_cyc.size() > 0 ? trig_cyc[0] : -1) !== 2) begin
        bad++; $display("FAIL rnd%0d_first_trig: got %0d want 2", it, trig_cyc.size() > 0 ? trig_cyc[0] : -1); end
      for (int k = 0; k < cap_beats.size(); k++) begin
        total++; if (cap_beats[k] !== snap || trig_idx[k] !== k) begin
          bad++; $display("FAIL rnd%0d_cap%0d: got beats=%0d idx=%0d want %0d %0d", it, k, cap_beats[k], trig_idx[k], snap, k); end
      end
      for (int k = 0; k < lb_cyc.size(); k++) begin
        total++; if (trig_cyc[k+1] - lb_cyc[k] !== hold + 3) begin
          bad++; $display("FAIL rnd%0d_gap%0d: got %0d want %0d", it, k, trig_cyc[k+1] - lb_cyc[k], hold + 3); end
      end
      total++; if (done_cnt !== 1 || done_cyc !== last_beat + 1) begin
        bad++; $display("FAIL rnd%0d_done: got count=%0d cycle=%0d want 1 %0d", it, done_cnt, done_cyc, last_beat + 1); end
    end
  endtask

  task automatic test_align_timeout();
    int to_val;
    for (int it = 0; it < 2; it++) begin
      to_val = (it == 0) ? 100 : $urandom_range(1, 20);
      @(posedge sys_clk); #1;
      aligned = 1'b0; align_timeout = TO_W'(to_val); snap_len = 16; num_captures = 1; start = 1'b1;
      clear_mon();
      for (int n = 0; n < 300; n++) begin
        @(posedge sys_clk); #1;
        start = 1'b0;
        if (n == 0) begin
          total++; if (err_align_to !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL to%0d_accept: got err=%0d busy=%0d want 0 1", it, err_align_to, busy); end
        end
        if (err_to_cyc >= 0) break;
      end
      total++; if (err_to_cyc !== to_val + 1) begin
        bad++; $display("FAIL to%0d_err_cycle: got %0d want %0d", it, err_to_cyc, to_val + 1); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL to%0d_idle: got busy=%0d want 0", it, busy); end
      repeat (3) @(posedge sys_clk); #1;
      mon_en = 1'b0;
      total++; if (trig_cyc.size() !== 0 || done_cnt !== 0) begin
        bad++; $display("FAIL to%0d_no_events: got trig=%0d done=%0d want 0 0", it, trig_cyc.size(), done_cnt); end
    end
    aligned = 1'b1; align_timeout = '0;
  endtask

  task automatic test_align_lost();
    @(posedge sys_clk); #1;
    aligned = 1'b1; axis_valid = 1'b1; axis_ready = 1'b1; snap_len = 16; num_captures = 1; start = 1'b1;
    clear_mon();
    for (int n = 0; n < 100; n++) begin
      @(posedge sys_clk); #1;
      start = 1'b0;
      if (beat_total == 4) begin aligned = 1'b0; axis_valid = 1'b0; break; end
    end
    @(posedge sys_clk); #1;
    total++; if (err_align_lost !== 1'b1 || capture_en !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL lost_state: got err=%0d capture_en=%0d busy=%0d want 1 0 0", err_align_lost, capture_en, busy); end
    total++; if (beat_cnt !== 4) begin bad++; $display("FAIL lost_beat_cnt: got %0d want 4", beat_cnt); end
    aligned = 1'b1; axis_valid = 1'b1;
    repeat (5) @(posedge sys_clk); #1;
    mon_en = 1'b0;
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL lost_no_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_abort();
    @(posedge sys_clk); #1;
    aligned = 1'b1; axis_valid = 1'b1; axis_ready = 1'b1; snap_len = 20; num_captures = 2; start = 1'b1;
    clear_mon();
    for (int n = 0; n < 50; n++) begin
      @(posedge sys_clk); #1;
      start = 1'b0;
      if (trig_cyc.size() > 0) break;
    end
    repeat (4) @(posedge sys_clk); #1;
    abort = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    total++; if (busy !== 1'b0 || capture_en !== 1'b0 || trigger !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%0d capture_en=%0d trigger=%0d want 0 0 0", busy, capture_en, trigger); end
    total++; if (beat_cnt !== beat_total) begin bad++; $display("FAIL abort_beat_cnt: got %0d want %0d", beat_cnt, beat_total); end
    repeat (20) @(posedge sys_clk); #1;
    mon_en = 1'b0;
    total++; if (done_cnt !== 0 || trig_cyc.size() !== 1) begin
      bad++; $display("FAIL abort_quiet: got done=%0d trig=%0d want 0 1", done_cnt, trig_cyc.size()); end
    total++; if ({err_cfg, err_align_to, err_align_lost} !== 3'b0) begin
      bad++; $display("FAIL abort_no_err: got %b want 000", {err_cfg, err_align_to, err_align_lost}); end
  endtask

  task automatic test_config_corners();
    @(posedge sys_clk); #1;
    snap_len = '0; num_captures = 3; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    total++; if (err_cfg !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL cfg_zero_len: got err_cfg=%0d busy=%0d want 1 0", err_cfg, busy); end
    snap_len = 5; num_captures = 1; start = 1'b1; abort = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge sys_clk); #1;
    total++; if (busy !== 1'b0 || err_cfg !== 1'b1) begin
      bad++; $display("FAIL cfg_start_abort: got busy=%0d err_cfg=%0d want 0 1", busy, err_cfg); end
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || err_cfg !== 1'b0) begin
      bad++; $display("FAIL cfg_clear_on_start: got busy=%0d err_cfg=%0d want 1 0", busy, err_cfg); end
    abort = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    num_captures = '0; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    total++; if (err_cfg !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL cfg_zero_ncap: got err_cfg=%0d busy=%0d want 1 0", err_cfg, busy); end
  endtask

  task automatic test_async_reset();
    @(posedge sys_clk); #1;
    aligned = 1'b1; axis_valid = 1'b1; axis_ready = 1'b1; snap_len = 30; num_captures = 2; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (4) @(posedge sys_clk);
    #3;
    total++; if (capture_en !== 1'b1) begin bad++; $display("FAIL rst_pre_active: got capture_en=%0d want 1", capture_en); end
    rst_n = 1'b0;
    #1;
    total++; if ({capture_en, trigger, busy, done, err_cfg, err_align_to, err_align_lost} !== 7'b0 ||
                 cap_idx !== '0 || beat_cnt !== '0) begin
      bad++; $display("FAIL rst_async: got flags=%b cap_idx=%0d beat_cnt=%0d want 0 0 0",
                      {capture_en, trigger, busy, done, err_cfg, err_align_to, err_align_lost}, cap_idx, beat_cnt); end
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge sys_clk); #1;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_random_runs();
    test_align_timeout();
    test_align_lost();
    test_abort();
    test_config_corners();
    test_async_reset();
    repeat (2) @(posedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
